hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL provide inputs id_rs and id_rt, each 5 bits, the source register fields of the instruction in ID.
REQ-004 SHALL provide inputs id_uses_rs and id_uses_rt, each 1 bit, high when the ID instruction reads that source.
REQ-005 SHALL provide inputs id_write_reg (5 bits, destination after reg_dst select), id_reg_write (1 bit) and id_mem_read (1 bit) for the ID instruction.
REQ-006 SHALL provide input id_valid, 1 bit, high when ID holds a real instruction.
REQ-007 SHALL provide input flush, 1 bit, high on a taken branch/jump to kill the ID instruction.
REQ-008 SHALL provide outputs ForwardA and ForwardB, each 2 bits, consumed by EX: 2'b10 selects EX_MEM_alu_result, 2'b01 selects MEM_WB data, 2'b00 selects the register-file operand.
REQ-009 SHALL provide output stall, 1 bit, which holds PC and IF/ID when high.
REQ-010 SHALL provide output id_ex_bubble, 1 bit, which zeroes the ID/EX control signals when high.
REQ-011 SHALL provide outputs wb_bypass_a and wb_bypass_b, each 1 bit, which select WB write data in place of the register-file read in ID.
REQ-012 SHALL provide output stall_count, 16 bits, a saturating count of stall cycles.

Function
REQ-013 SHALL keep shadow tags {dst, reg_write, mem_read} for the EX, MEM and WB stages, and SHALL shift them EX->MEM->WB every cycle.
REQ-014 SHALL load the EX tag from the ID inputs when the ID instruction advances: id_valid=1, stall=0, flush=0.
REQ-015 SHALL load a zeroed tag (reg_write=0, mem_read=0) into EX when id_valid=0, stall=1 or flush=1.
REQ-016 SHALL assert stall combinationally when EX.mem_read=1, EX.dst!=0, id_valid=1, flush=0, and either (id_uses_rs and id_rs==EX.dst) or (id_uses_rt and id_rt==EX.dst).
REQ-017 SHALL drive id_ex_bubble = stall | flush.
REQ-018 SHALL register ForwardA when the ID instruction advances, with 2'b10 taking priority over 2'b01:
- 2'b10 if id_uses_rs, EX.reg_write=1, EX.dst!=0 and EX.dst==id_rs (that producer is in MEM when the consumer is in EX);
- else 2'b01 if the same conditions hold against the MEM tag;
- else 2'b00.
REQ-019 SHALL compute ForwardB identically to ForwardA using id_rt and id_uses_rt.
REQ-020 SHALL register ForwardA = ForwardB = 2'b00 when a bubble enters EX.
REQ-021 SHALL make ForwardA/ForwardB valid in the cycle the consumer occupies EX, one cycle after advance.
REQ-022 SHALL assert wb_bypass_a combinationally when id_uses_rs, WB.reg_write=1, WB.dst!=0 and WB.dst==id_rs; wb_bypass_b SHALL follow the same rule with rt.
REQ-023 SHALL never forward or stall on register 0.
REQ-024 SHALL leave stall low on a load followed by a non-dependent instruction.
REQ-025 SHALL stall exactly one cycle for a load-use dependency; the consumer then advances with Forward=2'b01.
REQ-026 SHALL give flush priority when flush and the stall condition coincide: stall=0 and a bubble enters EX.
REQ-027 SHALL increment stall_count in every cycle where stall=1, and SHALL saturate it at 16'hFFFF without wrapping.

Reset
REQ-028 SHALL asynchronously clear all shadow tags to dst=0, reg_write=0, mem_read=0 while rst_n=0.
REQ-029 SHALL hold outputs during reset at ForwardA=ForwardB=2'b00, stall=0, id_ex_bubble=0, wb_bypass_a=wb_bypass_b=0 and stall_count=0.
REQ-030 SHALL lose all in-flight tags on reset assertion mid-operation; the first cycle after release behaves as an empty pipeline.

Structure
REQ-031 SHALL place the forward encodings FWD_NONE=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10 and the stage-tag record type in the shared pipeline package, which EX also uses.
REQ-032 SHALL implement the three stage tags with one sub-module, stage_tag_reg: a tag register with async reset and a bubble input, instantiated three times.

Verification
REQ-033 SHALL verify add $3,$1,$2 followed by sub $4,$3,$5 -> ForwardA=2'b10 in the sub's EX cycle, stall=0.
REQ-034 SHALL verify add $3 ; nop ; or $6,$7,$3 -> ForwardB=2'b01 in the or's EX cycle.
REQ-035 SHALL verify lw $8,0($1) followed by add $9,$8,$8 -> stall=1 and id_ex_bubble=1 for exactly one cycle, then ForwardA=ForwardB=2'b01 and stall_count=1.
REQ-036 SHALL verify add $0,$1,$2 followed by add $4,$0,$0 -> ForwardA=ForwardB=2'b00, stall=0.
REQ-037 SHALL verify a load-use pair with flush=1 in the same cycle -> stall=0, bubble enters EX, next ForwardA/B=2'b00.
REQ-038 SHALL verify rst_n pulsed low with a lw in EX -> all outputs 0 immediately; a dependent instruction after release gets no stall.

Source files
------------

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared pipeline definitions: forward-select encodings and the per-stage
// destination tag used by the hazard unit and the EX operand muxes.
package hazard_fwd_unit_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        FWD_NONE   = 2'b00,
        FWD_MEM_WB = 2'b01,
        FWD_EX_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic             reg_write;
        logic             mem_read;
    } stage_tag_t;

    localparam stage_tag_t TAG_EMPTY = stage_tag_t'('0);

    // A stage supplies a source operand only if it really writes a non-zero register.
    function automatic logic tag_produces(
        input stage_tag_t       tag,
        input logic [REG_W-1:0] src,
        input logic             uses
    );
        return uses && tag.reg_write && (tag.dst != '0) && (tag.dst == src);
    endfunction

    function automatic fwd_sel_t select_fwd(
        input stage_tag_t       ex_tag,
        input stage_tag_t       mem_tag,
        input logic [REG_W-1:0] src,
        input logic             uses
    );
        fwd_sel_t sel;
        if (tag_produces(ex_tag, src, uses))
            sel = FWD_EX_MEM;
        else if (tag_produces(mem_tag, src, uses))
            sel = FWD_MEM_WB;
        else
            sel = FWD_NONE;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_stage_tag.sv
// One pipeline stage's shadow tag; a bubble loads an empty tag in place of the input.
module stage_tag_reg
    import hazard_fwd_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bubble,
    input  stage_tag_t tag_d,
    output stage_tag_t tag_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tag_q <= TAG_EMPTY;
        else if (bubble)
            tag_q <= TAG_EMPTY;
        else
            tag_q <= tag_d;
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use stall detection, EX operand forwarding selects and WB->ID bypass,
// driven from shadow destination tags kept for the EX, MEM and WB stages.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_write_reg,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_valid,
    input  logic             flush,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             stall,
    output logic             id_ex_bubble,
    output logic             wb_bypass_a,
    output logic             wb_bypass_b,
    output logic [CNT_W-1:0] stall_count
);

    stage_tag_t id_tag;
    stage_tag_t ex_tag;
    stage_tag_t mem_tag;
    stage_tag_t wb_tag;
    logic       advance;
    logic       load_use;
    fwd_sel_t   fwd_a_nxt;
    fwd_sel_t   fwd_b_nxt;
    fwd_sel_t   fwd_a_q;
    fwd_sel_t   fwd_b_q;
    logic       unused_wb_mem_read;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (val == {CNT_W{1'b1}}) ? val : val + 1'b1;
    endfunction

    assign id_tag = '{dst: id_write_reg, reg_write: id_reg_write, mem_read: id_mem_read};

    // Hazard detection against the instruction currently in EX
    assign load_use = ex_tag.mem_read && (ex_tag.dst != '0) &&
                      ((id_uses_rs && (id_rs == ex_tag.dst)) ||
                       (id_uses_rt && (id_rt == ex_tag.dst)));

    assign stall        = load_use && id_valid && !flush;
    assign advance      = id_valid && !stall && !flush;
    assign id_ex_bubble = (stall || flush) && rst_n;

    assign fwd_a_nxt = select_fwd(ex_tag, mem_tag, id_rs, id_uses_rs);
    assign fwd_b_nxt = select_fwd(ex_tag, mem_tag, id_rt, id_uses_rt);

    assign wb_bypass_a = tag_produces(wb_tag, id_rs, id_uses_rs);
    assign wb_bypass_b = tag_produces(wb_tag, id_rt, id_uses_rt);

    assign unused_wb_mem_read = wb_tag.mem_read;

    // Shadow tags: ID -> EX -> MEM -> WB
    stage_tag_reg u_ex_tag (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (!advance),
        .tag_d  (id_tag),
        .tag_q  (ex_tag)
    );

    stage_tag_reg u_mem_tag (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (1'b0),
        .tag_d  (ex_tag),
        .tag_q  (mem_tag)
    );

    stage_tag_reg u_wb_tag (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (1'b0),
        .tag_d  (mem_tag),
        .tag_q  (wb_tag)
    );

    // Forward selects travel with the consumer into EX; bubbles carry none
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= FWD_NONE;
            fwd_b_q <= FWD_NONE;
        end else if (advance) begin
            fwd_a_q <= fwd_a_nxt;
            fwd_b_q <= fwd_b_nxt;
        end else begin
            fwd_a_q <= FWD_NONE;
            fwd_b_q <= FWD_NONE;
        end
    end

    assign ForwardA = fwd_a_q;
    assign ForwardB = fwd_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall)
            stall_count <= sat_inc(stall_count);
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: forwarding, load-use stall, flush and reset.
module tb_hazard_fwd_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  id_write_reg;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_valid;
    logic        flush;
    logic [1:0]  ForwardA;
    logic [1:0]  ForwardB;
    logic        stall;
    logic        id_ex_bubble;
    logic        wb_bypass_a;
    logic        wb_bypass_b;
    logic [15:0] stall_count;

    int checks = 0;
    int passes = 0;

    hazard_fwd_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_write_reg (id_write_reg),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_valid     (id_valid),
        .flush        (flush),
        .ForwardA     (ForwardA),
        .ForwardB     (ForwardB),
        .stall        (stall),
        .id_ex_bubble (id_ex_bubble),
        .wb_bypass_a  (wb_bypass_a),
        .wb_bypass_b  (wb_bypass_b),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic [4:0] wr, input logic rw, input logic mr);
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_write_reg = wr;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_valid     = 1'b1;
    endtask

    task automatic nop_id();
        id_rs        = '0;
        id_rt        = '0;
        id_uses_rs   = 1'b0;
        id_uses_rt   = 1'b0;
        id_write_reg = '0;
        id_reg_write = 1'b0;
        id_mem_read  = 1'b0;
        id_valid     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop_id();
        repeat (3) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        nop_id();
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("rst_fwd_a", 16'(ForwardA), 16'd0);
        check("rst_fwd_b", 16'(ForwardB), 16'd0);
        check("rst_stall", 16'(stall), 16'd0);
        check("rst_bubble_with_flush", 16'(id_ex_bubble), 16'd0);
        check("rst_wb_a", 16'(wb_bypass_a), 16'd0);
        check("rst_wb_b", 16'(wb_bypass_b), 16'd0);
        check("rst_count", stall_count, 16'd0);
        flush = 1'b0;
        rst_n = 1'b1;
        tick();

        // add $3,$1,$2 ; sub $4,$3,$5
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        check("exmem_stall", 16'(stall), 16'd0);
        tick();
        check("exmem_fwd_a", 16'(ForwardA), 16'd2);
        check("exmem_fwd_b", 16'(ForwardB), 16'd0);
        drain();

        // add $3 ; nop ; or $6,$7,$3
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        nop_id();
        tick();
        set_id(5'd7, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        tick();
        check("memwb_fwd_b", 16'(ForwardB), 16'd1);
        check("memwb_fwd_a", 16'(ForwardA), 16'd0);
        drain();

        // add $3 ; nop ; nop ; or $6,$7,$3 -> WB bypass in ID
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        nop_id();
        tick();
        tick();
        set_id(5'd7, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        #1;
        check("wb_bypass_b", 16'(wb_bypass_b), 16'd1);
        check("wb_bypass_a", 16'(wb_bypass_a), 16'd0);
        tick();
        check("wb_no_fwd_b", 16'(ForwardB), 16'd0);
        drain();

        // add $3 ; add $3 ; sub $4,$3,$5 -> youngest producer wins
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        tick();
        check("prio_fwd_a", 16'(ForwardA), 16'd2);
        drain();

        // lw $8,0($1) ; add $9,$8,$8
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        #1;
        check("lu_stall", 16'(stall), 16'd1);
        check("lu_bubble", 16'(id_ex_bubble), 16'd1);
        tick();
        check("lu_stall_released", 16'(stall), 16'd0);
        check("lu_bubble_released", 16'(id_ex_bubble), 16'd0);
        check("lu_bubble_fwd_a", 16'(ForwardA), 16'd0);
        check("lu_count", stall_count, 16'd1);
        tick();
        check("lu_fwd_a", 16'(ForwardA), 16'd1);
        check("lu_fwd_b", 16'(ForwardB), 16'd1);
        check("lu_count_held", stall_count, 16'd1);
        drain();

        // lw $8 ; add $9,$1,$2 -> no dependency
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        #1;
        check("nodep_stall", 16'(stall), 16'd0);
        drain();

        // add $0,$1,$2 ; add $4,$0,$0
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        check("r0_stall", 16'(stall), 16'd0);
        tick();
        check("r0_fwd_a", 16'(ForwardA), 16'd0);
        check("r0_fwd_b", 16'(ForwardB), 16'd0);
        drain();

        // lw $0 ; add $4,$0,$0 -> never stall on $0
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        check("r0_load_stall", 16'(stall), 16'd0);
        drain();

        // load-use with flush in the same cycle
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_stall", 16'(stall), 16'd0);
        check("flush_bubble", 16'(id_ex_bubble), 16'd1);
        tick();
        flush = 1'b0;
        nop_id();
        #1;
        check("flush_fwd_a", 16'(ForwardA), 16'd0);
        check("flush_fwd_b", 16'(ForwardB), 16'd0);
        check("flush_count", stall_count, 16'd1);
        drain();

        // reset mid-operation with lw in EX
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        #1;
        check("pre_rst_stall", 16'(stall), 16'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", 16'(stall), 16'd0);
        check("mid_rst_bubble", 16'(id_ex_bubble), 16'd0);
        check("mid_rst_fwd_a", 16'(ForwardA), 16'd0);
        check("mid_rst_count", stall_count, 16'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_stall", 16'(stall), 16'd0);
        tick();
        check("post_rst_fwd_a", 16'(ForwardA), 16'd0);
        check("post_rst_fwd_b", 16'(ForwardB), 16'd0);
        check("post_rst_count", stall_count, 16'd0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
